// File: rtl/mux_pipe_n_pkg.sv
// Shared encodings and skid-buffer state type for the mux_pipe_n select pipeline.
// Optional sticky out-of-range flag is enabled in the top with MUX_PIPE_SEL_ERR_EN.
package mux_pipe_n_pkg;

  localparam int DEF_WORD_WIDTH = 32;

  // Writeback source select encodings
  localparam logic [1:0] SEL_WB_ALU = 2'd0;
  localparam logic [1:0] SEL_WB_MEM = 2'd1;
  localparam logic [1:0] SEL_WB_PC4 = 2'd2;
  localparam logic [1:0] SEL_WB_IMM = 2'd3;

  // Destination register and ALU operand B select encodings
  localparam logic SEL_REGDST_RT  = 1'b0;
  localparam logic SEL_REGDST_RD  = 1'b1;
  localparam logic SEL_ALUSRC_REG = 1'b0;
  localparam logic SEL_ALUSRC_IMM = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/mux_pipe_skid.sv
// Width-generic 2-entry skid buffer: main register M drives the output, skid register S
// catches the word that arrives in the cycle downstream stalls. flush empties both.
module mux_pipe_skid
  import mux_pipe_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_payload,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_t      state_reg, state_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             accept;
  logic             emit;

  assign accept = in_valid & in_ready_reg;
  assign emit   = out_valid_reg & out_ready;

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    s_next     = s_reg;
    if (flush) begin
      // M is left alone so out_data keeps its last value after a flush
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            m_next     = in_payload;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (accept && !emit) begin
            s_next     = in_payload;
            state_next = FULL;
          end else if (emit && !accept) begin
            state_next = EMPTY;
          end else if (accept && emit) begin
            m_next = in_payload;
          end
        end
        FULL: begin
          if (emit) begin
            m_next     = s_reg;
            state_next = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      m_reg         <= '0;
      s_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      m_reg         <= m_next;
      s_reg         <= s_next;
      in_ready_reg  <= (state_next != FULL);
      out_valid_reg <= (state_next != EMPTY);
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_payload = m_reg;

endmodule

// File: rtl/mux_pipe_n.sv
// N-input word select feeding a registered valid/ready skid stage; selects >= NUM_IN give CONSTANT.
// Define MUX_PIPE_SEL_ERR_EN to get a sticky sel_err flag for out-of-range selects.
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter int          WORD_WIDTH = mux_pipe_n_pkg::DEF_WORD_WIDTH,
  parameter int          NUM_IN     = 4,
  parameter int          SEL_WIDTH  = 2,
  parameter int unsigned CONSTANT   = 29
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*WORD_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         in_sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [WORD_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sel_err
);

  localparam int NUM_SLOTS = 1 << SEL_WIDTH;

  if (NUM_IN < 2 || NUM_IN > 16 || NUM_SLOTS < NUM_IN) begin : g_bad_cfg
    $error("mux_pipe_n: NUM_IN must be 2..16 and fit in SEL_WIDTH select bits");
  end

  // Every select code maps to a slot; unused codes read the constant
  logic [WORD_WIDTH-1:0] slot_word [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] sel_word;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    if (gi < NUM_IN) begin : g_in
      assign slot_word[gi] = in_data[gi*WORD_WIDTH +: WORD_WIDTH];
    end else begin : g_const
      assign slot_word[gi] = WORD_WIDTH'(CONSTANT);
    end
  end

  assign sel_word = slot_word[in_sel];

  mux_pipe_skid #(
    .WIDTH(SEL_WIDTH + WORD_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_payload ({in_sel, sel_word}),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_payload({out_sel, out_data}),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

`ifdef MUX_PIPE_SEL_ERR_EN
  logic sel_err_reg;
  logic accept;

  // A flushed cycle drops its word, so it cannot raise the flag either
  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else if (accept && ({1'b0, in_sel} >= (SEL_WIDTH+1)'(NUM_IN))) begin
      sel_err_reg <= 1'b1;
    end
  end

  assign sel_err = sel_err_reg;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed checks of mux_pipe_n: select, streaming, backpressure, out-of-range, flush, async reset.
module tb_mux_pipe_n;

  localparam int W = 32;

`ifdef MUX_PIPE_SEL_ERR_EN
  localparam logic SEL_ERR_EXP = 1'b1;
`else
  localparam logic SEL_ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: 4 inputs
  logic [4*W-1:0] a_in_data = '0;
  logic [1:0]     a_in_sel = '0;
  logic           a_in_valid = 1'b0;
  logic           a_in_ready;
  logic           a_flush = 1'b0;
  logic [W-1:0]   a_out_data;
  logic [1:0]     a_out_sel;
  logic           a_out_valid;
  logic           a_out_ready = 1'b0;
  logic           a_sel_err;

  // DUT b: 3 inputs, so select 3 is out of range
  logic [3*W-1:0] b_in_data = '0;
  logic [1:0]     b_in_sel = '0;
  logic           b_in_valid = 1'b0;
  logic           b_in_ready;
  logic           b_flush = 1'b0;
  logic [W-1:0]   b_out_data;
  logic [1:0]     b_out_sel;
  logic           b_out_valid;
  logic           b_out_ready = 1'b0;
  logic           b_sel_err;

  int n_checks = 0;
  int n_fail = 0;

  mux_pipe_n #(.WORD_WIDTH(W), .NUM_IN(4), .SEL_WIDTH(2), .CONSTANT(29)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sel_err(a_sel_err)
  );

  mux_pipe_n #(.WORD_WIDTH(W), .NUM_IN(3), .SEL_WIDTH(2), .CONSTANT(29)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sel_err(b_sel_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four words k -> base + k, so the selected word is base + sel
  task automatic put_a(input logic [W-1:0] base, input logic [1:0] sel);
    for (int k = 0; k < 4; k++) a_in_data[k*W +: W] = base + W'(k);
    a_in_sel   = sel;
    a_in_valid = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_a_valid", W'(a_out_valid), 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_sel", W'(a_out_sel), 0);
    chk("rst_a_ready", W'(a_in_ready), 1);
    chk("rst_a_selerr", W'(a_sel_err), 0);
    chk("rst_b_selerr", W'(b_sel_err), 0);
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // 1: single capture, in_data = {4,3,2,1}, sel 2 -> 3
    a_in_data = {32'd4, 32'd3, 32'd2, 32'd1};
    a_in_sel = 2'd2; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    $display("t1 single capture sel=2");
    chk("t1_valid", W'(a_out_valid), 1);
    chk("t1_data", a_out_data, 3);
    chk("t1_sel", W'(a_out_sel), 2);
    tick();
    chk("t1_drain_valid", W'(a_out_valid), 0);
    chk("t1_drain_data_held", a_out_data, 3);

    // 2: streaming, one word per cycle
    for (int i = 0; i < 8; i++) begin
      put_a(W'(16 * i), 2'(i % 4));
      tick();
      $display("t2 stream word %0d sel=%0d", i, i % 4);
      chk("t2_valid", W'(a_out_valid), 1);
      chk("t2_data", a_out_data, W'(16 * i + (i % 4)));
      chk("t2_ready", W'(a_in_ready), 1);
    end
    a_in_valid = 1'b0;
    tick();
    chk("t2_drain_valid", W'(a_out_valid), 0);

    // 3: backpressure, A = 0xA1 (sel 1), B = 0xB3 (sel 3)
    a_out_ready = 1'b0;
    put_a(32'hA0, 2'd1);
    tick();
    $display("t3 send A");
    chk("t3_a_valid", W'(a_out_valid), 1);
    chk("t3_a_data", a_out_data, 32'hA1);
    chk("t3_a_ready", W'(a_in_ready), 1);
    put_a(32'hB0, 2'd3);
    tick();
    a_in_valid = 1'b0;
    $display("t3 send B under stall");
    chk("t3_full_ready", W'(a_in_ready), 0);
    chk("t3_full_data", a_out_data, 32'hA1);
    tick();
    chk("t3_hold_data", a_out_data, 32'hA1);
    chk("t3_hold_sel", W'(a_out_sel), 1);
    chk("t3_hold_ready", W'(a_in_ready), 0);
    a_out_ready = 1'b1;
    tick();
    $display("t3 release, A emitted");
    chk("t3_b_valid", W'(a_out_valid), 1);
    chk("t3_b_data", a_out_data, 32'hB3);
    chk("t3_b_sel", W'(a_out_sel), 3);
    chk("t3_b_ready", W'(a_in_ready), 1);
    tick();
    $display("t3 B emitted");
    chk("t3_empty_valid", W'(a_out_valid), 0);

    // 4: out-of-range select on the 3-input instance
    b_in_data = {32'd3, 32'd2, 32'd1};
    b_in_sel = 2'd3; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    $display("t4 sel=3 on NUM_IN=3");
    chk("t4_const_valid", W'(b_out_valid), 1);
    chk("t4_const_data", b_out_data, 29);
    chk("t4_const_sel", W'(b_out_sel), 3);
    chk("t4_selerr", W'(b_sel_err), W'(SEL_ERR_EXP));
    b_in_sel = 2'd2;
    tick();
    b_in_valid = 1'b0;
    $display("t4 sel=2 in range");
    chk("t4_inrange_data", b_out_data, 3);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    $display("t4 flush");
    chk("t4_flush_valid", W'(b_out_valid), 0);
    chk("t4_selerr_sticky", W'(b_sel_err), W'(SEL_ERR_EXP));
    chk("t4_a_selerr_clear", W'(a_sel_err), 0);

    // 5: FULL plus flush with a live input
    a_out_ready = 1'b0;
    put_a(32'hC0, 2'd0);
    tick();
    put_a(32'hD0, 2'd1);
    tick();
    chk("t5_full_ready", W'(a_in_ready), 0);
    put_a(32'hE0, 2'd2);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    $display("t5 flush while FULL");
    chk("t5_flush_valid", W'(a_out_valid), 0);
    chk("t5_flush_ready", W'(a_in_ready), 1);
    chk("t5_flush_data_kept", a_out_data, 32'hC0);
    a_out_ready = 1'b1;
    tick();
    chk("t5_dropped_valid", W'(a_out_valid), 0);
    put_a(32'hF0, 2'd3);
    tick();
    a_in_valid = 1'b0;
    $display("t5 fresh word after flush");
    chk("t5_fresh_data", a_out_data, 32'hF3);
    tick();
    chk("t5_no_stale_skid", W'(a_out_valid), 0);

    // 6: async reset between edges while FULL
    a_out_ready = 1'b0;
    put_a(32'h10, 2'd1);
    tick();
    put_a(32'h20, 2'd2);
    tick();
    a_in_valid = 1'b0;
    chk("t6_full_ready", W'(a_in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("t6 async reset mid-cycle");
    chk("t6_rst_valid", W'(a_out_valid), 0);
    chk("t6_rst_ready", W'(a_in_ready), 1);
    chk("t6_rst_data", a_out_data, 0);
    chk("t6_rst_selerr", W'(b_sel_err), 0);
    tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    chk("t6_no_stale", W'(a_out_valid), 0);
    put_a(32'h30, 2'd0);
    tick();
    a_in_valid = 1'b0;
    $display("t6 first word after reset");
    chk("t6_new_data", a_out_data, 32'h30);
    tick();
    chk("t6_new_drain", W'(a_out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
